// File: rtl/csel_addsub_pipe.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake and carry/overflow/zero flags.
// Each stage resolves BLK_PER_STG carry-select blocks and forwards the unresolved operand bits.
module csel_addsub_pipe #(
  parameter int WIDTH       = 32,
  parameter int BLK         = 4,
  parameter int BLK_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = WIDTH / BLK;
  localparam int NSTG = (NBLK + BLK_PER_STG - 1) / BLK_PER_STG;

  if (WIDTH % BLK != 0) begin : g_bad_width
    $fatal(1, "csel_addsub_pipe: WIDTH must be a multiple of BLK");
  end

  // Resolves blocks lo..hi-1: both carry-in candidates are formed, the running carry picks one.
  function automatic logic [WIDTH:0] resolve_blocks(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH-1:0] part_sum,
    input logic             carry,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] s_v;
    logic             c_v;
    logic [BLK:0]     p0_v;
    logic [BLK:0]     p1_v;
    s_v = part_sum;
    c_v = carry;
    for (int k = 0; k < NBLK; k++) begin
      if (k >= lo && k < hi) begin
        p0_v = {1'b0, op_a[k*BLK +: BLK]} + {1'b0, op_b[k*BLK +: BLK]};
        p1_v = {1'b0, op_a[k*BLK +: BLK]} + {1'b0, op_b[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        s_v[k*BLK +: BLK] = c_v ? p1_v[BLK-1:0] : p0_v[BLK-1:0];
        c_v = c_v ? p1_v[BLK] : p0_v[BLK];
      end else begin
        s_v = s_v;
      end
    end
    return {c_v, s_v};
  endfunction

  logic stall_s;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  for (genvar j = 0; j < NSTG; j++) begin : g_stg
    localparam int LO = j * BLK_PER_STG;
    localparam int HI = ((j + 1) * BLK_PER_STG < NBLK) ? (j + 1) * BLK_PER_STG : NBLK;

    logic             vld_in_s;
    logic             c_in_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;
    logic [WIDTH-1:0] s_in_s;
    logic [WIDTH:0]   res_s;
    logic             vld_r;
    logic             c_r;
    logic [WIDTH-1:0] s_r;

    if (j == 0) begin : g_head
      // Subtract is a + ~b + 1, so the inverted operand and a forced carry enter here.
      assign vld_in_s = in_valid & ~stall_s;
      assign a_in_s   = a;
      assign b_in_s   = sub ? ~b : b;
      assign s_in_s   = '0;
      assign c_in_s   = sub ? 1'b1 : cin;
    end else begin : g_body
      assign vld_in_s = g_stg[j-1].vld_r;
      assign a_in_s   = g_stg[j-1].g_fwd.a_r;
      assign b_in_s   = g_stg[j-1].g_fwd.b_r;
      assign s_in_s   = g_stg[j-1].s_r;
      assign c_in_s   = g_stg[j-1].c_r;
    end

    assign res_s = resolve_blocks(a_in_s, b_in_s, s_in_s, c_in_s, LO, HI);

    // Stage register for valid, partial sum and running carry; frozen (bubbles too) on stall.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= 1'b0;
        s_r   <= '0;
        c_r   <= 1'b0;
      end else if (!stall_s) begin
        vld_r <= vld_in_s;
        s_r   <= res_s[WIDTH-1:0];
        c_r   <= res_s[WIDTH];
      end
    end

    if (j < NSTG - 1) begin : g_fwd
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Operand forwarding register feeding the blocks resolved by later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (!stall_s) begin
          a_r <= a_in_s;
          b_r <= b_in_s;
        end
      end
    end
  end

  logic ovf_r;
  logic zero_r;

  // Final-stage flags; the carry into the MSB is recovered as a^b^sum at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (!stall_s) begin
      ovf_r  <= g_stg[NSTG-1].a_in_s[WIDTH-1] ^ g_stg[NSTG-1].b_in_s[WIDTH-1]
              ^ g_stg[NSTG-1].res_s[WIDTH-1] ^ g_stg[NSTG-1].res_s[WIDTH];
      zero_r <= ~|g_stg[NSTG-1].res_s[WIDTH-1:0];
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_r;
  assign sum       = g_stg[NSTG-1].s_r;
  assign cout      = g_stg[NSTG-1].c_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Directed bench for csel_addsub_pipe: default 32-bit pipe plus 16-bit/4-stage and 8-bit/1-stage variants.
module tb_csel_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int vectors = 0;
  int miscompares = 0;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, s16;

  logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;

  csel_addsub_pipe #(.WIDTH(32), .BLK(4), .BLK_PER_STG(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .zero(zero));

  csel_addsub_pipe #(.WIDTH(16), .BLK(4), .BLK_PER_STG(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
    .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16),
    .zero(z16));

  csel_addsub_pipe #(.WIDTH(8), .BLK(8), .BLK_PER_STG(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
    .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8),
    .zero(z8));

  // Reference result packed as {zero, ovf, cout, sum}.
  function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic [31:0] ye;
    logic [32:0] t;
    logic        v;
    ye = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {32'd0, (sb | ci)};
    v  = (x[31] == ye[31]) && (t[31] != x[31]);
    return {(t[31:0] == 32'd0), v, t[32], t[31:0]};
  endfunction

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic ts, output int lat);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input logic ts, output int lat);
    @(negedge clk);
    a16 = ta; b16 = tb; ci16 = tc; sb16 = ts; iv16 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv16 = 1'b0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb; ci8 = tc; sb8 = ts; iv8 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv8 = 1'b0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    vectors++; if (sum !== 32'd0) begin miscompares++; $display("FAIL reset_sum: got %h want 0", sum); end
    vectors++; if ({cout, ovf, zero} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    vectors++; if ({ov16, ov8} !== 2'b00) begin miscompares++; $display("FAIL reset_small_valid: got %b want 00", {ov16, ov8}); end
    rst = 1'b0;
  endtask

  task automatic test_add_wrap();
    int lat;
    run32(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    vectors++; if (sum !== 32'd0) begin miscompares++; $display("FAIL wrap_sum: got %h want 0", sum); end
    vectors++; if ({cout, ovf, zero} !== 3'b101) begin miscompares++; $display("FAIL wrap_flags(c,o,z): got %b want 101", {cout, ovf, zero}); end
  endtask

  task automatic test_ovf_sub();
    int lat;
    run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    vectors++; if (sum !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_sum: got %h want 80000000", sum); end
    vectors++; if ({cout, ovf, zero} !== 3'b010) begin miscompares++; $display("FAIL ovf_flags(c,o,z): got %b want 010", {cout, ovf, zero}); end
    run32(32'd5, 32'd7, 1'b0, 1'b1, lat);
    vectors++; if (sum !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_borrow_sum: got %h want fffffffe", sum); end
    vectors++; if ({cout, ovf, zero} !== 3'b000) begin miscompares++; $display("FAIL sub_borrow_flags(c,o,z): got %b want 000", {cout, ovf, zero}); end
    run32(32'd10, 32'd3, 1'b1, 1'b1, lat);
    vectors++; if ({cout, sum} !== {1'b1, 32'd7}) begin miscompares++; $display("FAIL sub_ignores_cin: got %b/%h want 1/00000007", cout, sum); end
    run32(32'h0000_FFFF, 32'd0, 1'b1, 1'b0, lat);
    vectors++; if ({cout, sum} !== {1'b0, 32'h0001_0000}) begin miscompares++; $display("FAIL add_cin_ripple: got %b/%h want 0/00010000", cout, sum); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp_q[$];
    logic [34:0] e;
    logic [31:0] ra, rb;
    logic        rc, rs;
    int sent = 0, got = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra_result: got %h want none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, ovf, cout, sum} !== e) begin miscompares++; $display("FAIL b2b_result%0d: got %h want %h", got, {zero, ovf, cout, sum}, e); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < 16) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
        exp_q.push_back(model32(ra, rb, rc, rs));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    vectors++; if (got !== 16) begin miscompares++; $display("FAIL b2b_count: got %0d want 16", got); end
    vectors++; if (first !== 4) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 4", first); end
    vectors++; if (last - first !== 15) begin miscompares++; $display("FAIL b2b_consecutive: got span %0d want 15", last - first); end
  endtask

  task automatic test_stall();
    logic [34:0] exp_q[$];
    logic [34:0] e, snap;
    logic [31:0] ba, bb;
    logic        bs;
    int sent = 0, got = 0;
    snap = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 10);
      #1;
      if (cyc >= 4 && cyc < 10) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready cyc%0d: got %0b want 0", cyc, in_ready); end
        if (cyc == 4) snap = {zero, ovf, cout, sum};
        else begin
          vectors++; if ({zero, ovf, cout, sum} !== snap) begin miscompares++; $display("FAIL stall_stable cyc%0d: got %h want %h", cyc, {zero, ovf, cout, sum}, snap); end
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL stall_extra_result: got %h want none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, ovf, cout, sum} !== e) begin miscompares++; $display("FAIL stall_result%0d: got %h want %h", got, {zero, ovf, cout, sum}, e); end
        end
        got++;
      end
      if (sent < 8) begin
        ba = 32'h1234_5678 + 32'(sent) * 32'h0101_0101;
        bb = 32'h0F0F_0F0F ^ 32'(sent);
        bs = 1'(sent % 2);
        a = ba; b = bb; cin = 1'b1; sub = bs; in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back(model32(ba, bb, 1'b1, bs));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++; if (got !== 8) begin miscompares++; $display("FAIL stall_count: got %0d want 8", got); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic stale = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        a = 32'(cyc + 1); b = 32'd100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid: got %0b want 1", out_valid); end
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_drop: got %0b want 0", out_valid); end
    vectors++; if (sum !== 32'd0) begin miscompares++; $display("FAIL rstmid_sum: got %h want 0", sum); end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale: got %0b want 0", stale); end
  endtask

  task automatic test_sweep();
    int lat;
    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL w16_latency: got %0d want 4", lat); end
    vectors++; if (s16 !== 16'h0100) begin miscompares++; $display("FAIL w16_sum: got %h want 0100", s16); end
    run16(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    vectors++; if ({co16, of16, z16, s16} !== {3'b111, 16'h0000}) begin miscompares++; $display("FAIL w16_wrap(c,o,z,sum): got %b %h want 111 0000", {co16, of16, z16}, s16); end
    run16(16'h0003, 16'h0005, 1'b0, 1'b1, lat);
    vectors++; if ({co16, s16} !== {1'b0, 16'hFFFE}) begin miscompares++; $display("FAIL w16_sub: got %b/%h want 0/fffe", co16, s16); end
    run8(8'hFF, 8'h00, 1'b1, 1'b0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL w8_latency: got %0d want 1", lat); end
    vectors++; if ({co8, of8, z8, s8} !== {3'b101, 8'h00}) begin miscompares++; $display("FAIL w8_cin_ripple(c,o,z,sum): got %b %h want 101 00", {co8, of8, z8}, s8); end
    run8(8'h7F, 8'h00, 1'b1, 1'b0, lat);
    vectors++; if ({co8, of8, s8} !== {2'b01, 8'h80}) begin miscompares++; $display("FAIL w8_ovf(c,o,sum): got %b %h want 01 80", {co8, of8}, s8); end
    run8(8'h10, 8'h20, 1'b0, 1'b1, lat);
    vectors++; if ({co8, s8} !== {1'b0, 8'hF0}) begin miscompares++; $display("FAIL w8_sub: got %b/%h want 0/f0", co8, s8); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0;
    test_reset();
    test_add_wrap();
    test_ovf_sub();
    test_back_to_back();
    repeat (6) @(negedge clk);
    test_stall();
    repeat (6) @(negedge clk);
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
